// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one access at a time, stalls the core,
// steers byte lanes on the data bus and extends load data for write-back.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [4:0]  ALUop_i,
   input  logic [31:0] MemAddr_i,
   input  logic [31:0] StoreData_i,
   input  logic [4:0]  WriteDataNum_i,
   output logic        busy_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        wb_valid_o,
   output logic        WriteReg_o,
   output logic [4:0]  WriteDataNum_o,
   output logic [31:0] WriteData_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  rd_q, rd_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  code_q, code_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  wnum_q, wnum_d;

   logic        legal;
   logic        misaligned;
   logic        accept;
   logic [31:0] shifted;
   logic [31:0] ext;

   always_comb begin
      legal = 1'b0;
      unique case (ALUop_i)
         5'b10000, 5'b10001, 5'b10010,
         5'b10100, 5'b10101,
         5'b11000, 5'b11001, 5'b11010: legal = 1'b1;
         default:                      legal = 1'b0;
      endcase
   end

   assign misaligned = ((ALUop_i[1:0] == 2'b01) && MemAddr_i[0]) ||
                       ((ALUop_i[1:0] == 2'b10) && (MemAddr_i[1:0] != 2'b00));
   assign accept     = (state_q == S_IDLE) && req_valid && legal;
   assign busy_o     = rst_n && ((state_q != S_IDLE) || accept);

   // op_q[3]=store, op_q[2]=unsigned, op_q[1:0]=size
   assign shifted = bus_rdata_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      ext = shifted;
      unique case (op_q[1:0])
         2'b00:   ext = {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
         2'b01:   ext = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      wdata_d = wdata_q;
      wnum_d  = wnum_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d   = ALUop_i[3:0];
               addr_d = MemAddr_i;
               data_d = StoreData_i;
               rd_d   = WriteDataNum_i;
               cnt_d  = 8'd0;
               if (misaligned) begin
                  code_d  = 2'b01;
                  state_d = S_RESP;
               end else begin
                  code_d  = 2'b00;
                  state_d = S_BUS;
               end
            end
         end
         S_BUS: begin
            if (bus_ack_i) begin
               state_d = S_RESP;
               if (!op_q[3]) begin
                  wdata_d = ext;
                  wnum_d  = rd_q;
               end
            end else if (cnt_q == TO_LAST) begin
               code_d  = 2'b10;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         wdata_q <= '0;
         wnum_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         wdata_q <= wdata_d;
         wnum_q  <= wnum_d;
      end
   end

   always_comb begin
      bus_req_o   = 1'b0;
      bus_we_o    = 1'b0;
      bus_addr_o  = '0;
      bus_be_o    = '0;
      bus_wdata_o = '0;
      if (state_q == S_BUS) begin
         bus_req_o  = 1'b1;
         bus_we_o   = op_q[3];
         bus_addr_o = {addr_q[31:2], 2'b00};
         unique case (op_q[1:0])
            2'b00: begin
               bus_be_o    = 4'b0001 << addr_q[1:0];
               bus_wdata_o = {4{data_q[7:0]}};
            end
            2'b01: begin
               bus_be_o    = 4'b0011 << addr_q[1:0];
               bus_wdata_o = {2{data_q[15:0]}};
            end
            default: begin
               bus_be_o    = 4'b1111;
               bus_wdata_o = data_q;
            end
         endcase
         if (!op_q[3]) bus_wdata_o = '0;
      end
   end

   assign wb_valid_o     = (state_q == S_RESP) && !op_q[3] && (code_q == 2'b00);
   assign WriteReg_o     = wb_valid_o;
   assign WriteDataNum_o = wnum_q;
   assign WriteData_o    = wdata_q;
   assign err_o          = (state_q == S_RESP) && (code_q != 2'b00);
   assign err_code_o     = (state_q == S_RESP) ? code_q : 2'b00;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with a response scoreboard.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [4:0]  ALUop_i = '0;
   logic [31:0] MemAddr_i = '0;
   logic [31:0] StoreData_i = '0;
   logic [4:0]  WriteDataNum_i = '0;
   logic        busy_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i = 1'b0;
   logic [31:0] bus_rdata_i = '0;
   logic        wb_valid_o;
   logic        WriteReg_o;
   logic [4:0]  WriteDataNum_o;
   logic [31:0] WriteData_o;
   logic        err_o;
   logic [1:0]  err_code_o;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
      .ALUop_i(ALUop_i), .MemAddr_i(MemAddr_i),
      .StoreData_i(StoreData_i), .WriteDataNum_i(WriteDataNum_i),
      .busy_o(busy_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
      .bus_rdata_i(bus_rdata_i), .wb_valid_o(wb_valid_o),
      .WriteReg_o(WriteReg_o), .WriteDataNum_o(WriteDataNum_o),
      .WriteData_o(WriteData_o), .err_o(err_o), .err_code_o(err_code_o)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] LB = 5'b10000, LH = 5'b10001, LW = 5'b10010;
   localparam logic [4:0] LBU = 5'b10100, LHU = 5'b10101;
   localparam logic [4:0] SB = 5'b11000, SH = 5'b11001, SW = 5'b11010;

   typedef struct packed {
      logic        err;
      logic [1:0]  code;
      logic [4:0]  num;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int total = 0;
   int bad = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (wb_valid_o || err_o)) begin
         total++;
         if (WriteReg_o !== wb_valid_o) begin
            bad++;
            $display("FAIL wreg_eq_wb got=%b exp=%b", WriteReg_o, wb_valid_o);
         end
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected wb=%b err=%b code=%b",
                     wb_valid_o, err_o, err_code_o);
         end else begin
            e = sb_q.pop_front();
            if (e.err) begin
               if ({err_o, err_code_o, wb_valid_o} !== {1'b1, e.code, 1'b0}) begin
                  bad++;
                  $display("FAIL sb_err got err=%b code=%b wb=%b exp code=%b",
                           err_o, err_code_o, wb_valid_o, e.code);
               end
            end else if ({wb_valid_o, err_o, WriteDataNum_o, WriteData_o} !==
                         {1'b1, 1'b0, e.num, e.data}) begin
               bad++;
               $display("FAIL sb_wb got wb=%b err=%b rd=%0d data=%h exp rd=%0d data=%h",
                        wb_valid_o, err_o, WriteDataNum_o, WriteData_o, e.num, e.data);
            end
         end
      end
   end

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e = '{err: 1'b0, code: 2'b00, num: rd, data: d};
      sb_q.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] c);
      exp_t e;
      e = '{err: 1'b1, code: c, num: 5'd0, data: 32'd0};
      sb_q.push_back(e);
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
      req_valid = 1'b1;
      ALUop_i = op;
      MemAddr_i = a;
      StoreData_i = d;
      WriteDataNum_i = rd;
      #1;
      total++;
      if (busy_o !== 1'b1) begin
         bad++;
         $display("FAIL accept_busy got=%b exp=1", busy_o);
      end
      clk1();
      req_valid = 1'b0;
   endtask

   task automatic bus_phase(input int nwait, input logic [31:0] rdata,
                            input logic [3:0] be, input logic [31:0] ad,
                            input logic we, input logic [31:0] wd,
                            output int busy_n);
      busy_n = 0;
      for (int i = 0; i <= nwait; i++) begin
         total++;
         if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o} !==
             {1'b1, we, be, ad, wd}) begin
            bad++;
            $display("FAIL bus_hold cyc=%0d got req=%b we=%b be=%b addr=%h wd=%h exp we=%b be=%b addr=%h wd=%h",
                     i, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
                     we, be, ad, wd);
         end
         if (busy_o) busy_n++;
         if (i == nwait) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = rdata;
         end
         clk1();
      end
      bus_ack_i = 1'b0;
      bus_rdata_i = '0;
      if (busy_o) busy_n++;
   endtask

   task automatic check_idle(input string tag);
      total++;
      if ({busy_o, bus_req_o, wb_valid_o, err_o} !== 4'b0000) begin
         bad++;
         $display("FAIL %s_idle got busy=%b req=%b wb=%b err=%b exp=0000",
                  tag, busy_o, bus_req_o, wb_valid_o, err_o);
      end
   endtask

   task automatic do_load(input logic [4:0] op, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int nwait, input logic [3:0] be,
                          input logic [31:0] exp_d, input string tag);
      int n;
      issue(op, a, 32'h0, rd);
      push_wb(rd, exp_d);
      bus_phase(nwait, rdata, be, {a[31:2], 2'b00}, 1'b0, 32'h0, n);
      total++;
      if ({wb_valid_o, WriteData_o, WriteDataNum_o} !== {1'b1, exp_d, rd}) begin
         bad++;
         $display("FAIL %s_wb got wb=%b data=%h rd=%0d exp wb=1 data=%h rd=%0d",
                  tag, wb_valid_o, WriteData_o, WriteDataNum_o, exp_d, rd);
      end
      clk1();
      check_idle(tag);
   endtask

   task automatic do_store(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] d, input int nwait,
                           input logic [3:0] be, input logic [31:0] wd,
                           output int busy_n);
      issue(op, a, d, 5'd0);
      bus_phase(nwait, 32'h0, be, {a[31:2], 2'b00}, 1'b1, wd, busy_n);
      total++;
      if ({wb_valid_o, WriteReg_o, err_o} !== 3'b000) begin
         bad++;
         $display("FAIL store_nowb got wb=%b wreg=%b err=%b exp=000",
                  wb_valid_o, WriteReg_o, err_o);
      end
      clk1();
      check_idle("store");
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
           wb_valid_o, WriteReg_o, WriteDataNum_o, WriteData_o, err_o,
           err_code_o} !== '0) begin
         bad++;
         $display("FAIL reset_outs got nonzero req=%b wb=%b data=%h err=%b",
                  bus_req_o, wb_valid_o, WriteData_o, err_o);
      end
      rst_n = 1'b1;
      clk1();
   endtask

   task automatic test_illegal_op();
      req_valid = 1'b1;
      ALUop_i = 5'b00011;
      MemAddr_i = 32'h100;
      #1;
      total++;
      if (busy_o !== 1'b0) begin
         bad++;
         $display("FAIL illegal_busy got=%b exp=0", busy_o);
      end
      clk1();
      req_valid = 1'b0;
      check_idle("illegal");
   endtask

   task automatic test_loads();
      do_load(LB, 32'h103, 5'd5, 32'h80FFFFFF, 0, 4'b1000, 32'hFFFFFF80, "lb");
      total++;
      if (WriteData_o !== 32'hFFFFFF80) begin
         bad++;
         $display("FAIL hold_data got=%h exp=ffffff80", WriteData_o);
      end
      do_load(LHU, 32'h102, 5'd6, 32'h9ABC1234, 0, 4'b1100, 32'h00009ABC, "lhu");
      do_load(LH, 32'h102, 5'd7, 32'h9ABC1234, 1, 4'b1100, 32'hFFFF9ABC, "lh");
      do_load(LBU, 32'h101, 5'd8, 32'h00008000, 2, 4'b0010, 32'h00000080, "lbu");
      do_load(LH, 32'h100, 5'd9, 32'h12347FFF, 0, 4'b0011, 32'h00007FFF, "lh_lo");
      do_load(LW, 32'h100, 5'd10, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, "lw");
   endtask

   task automatic test_stores();
      int n;
      do_store(SB, 32'h201, 32'h123456A5, 3, 4'b0010, 32'hA5A5A5A5, n);
      total++;
      if (n != 5) begin
         bad++;
         $display("FAIL sb_busy_cycles got=%0d exp=5", n);
      end
      do_store(SH, 32'h202, 32'hFFFF1234, 0, 4'b1100, 32'h12341234, n);
      do_store(SW, 32'h300, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D, n);
   endtask

   task automatic test_misaligned();
      issue(LW, 32'h102, 32'h0, 5'd3);
      push_err(2'b01);
      total++;
      if ({bus_req_o, err_o, err_code_o, wb_valid_o} !== {1'b0, 1'b1, 2'b01, 1'b0}) begin
         bad++;
         $display("FAIL mis_lw got req=%b err=%b code=%b wb=%b exp 0 1 01 0",
                  bus_req_o, err_o, err_code_o, wb_valid_o);
      end
      clk1();
      check_idle("mis_lw");
      issue(SH, 32'h203, 32'h0, 5'd0);
      push_err(2'b01);
      total++;
      if ({bus_req_o, err_o, err_code_o} !== {1'b0, 1'b1, 2'b01}) begin
         bad++;
         $display("FAIL mis_sh got req=%b err=%b code=%b exp 0 1 01",
                  bus_req_o, err_o, err_code_o);
      end
      clk1();
      check_idle("mis_sh");
   endtask

   task automatic test_timeout();
      int n = 0;
      issue(LW, 32'h400, 32'h0, 5'd11);
      push_err(2'b10);
      while (bus_req_o && n < 10) begin
         n++;
         clk1();
      end
      total++;
      if (n != TO) begin
         bad++;
         $display("FAIL to_req_cycles got=%0d exp=%0d", n, TO);
      end
      total++;
      if ({err_o, err_code_o, WriteReg_o} !== {1'b1, 2'b10, 1'b0}) begin
         bad++;
         $display("FAIL to_err got err=%b code=%b wreg=%b exp 1 10 0",
                  err_o, err_code_o, WriteReg_o);
      end
      clk1();
      check_idle("to");
      do_load(LW, 32'h404, 5'd12, 32'h0BADF00D, TO - 1, 4'b1111, 32'h0BADF00D, "ack_wins");
   endtask

   task automatic test_reset_mid();
      int n;
      issue(LW, 32'h500, 32'h0, 5'd13);
      clk1();
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy_o, bus_req_o, bus_be_o, bus_addr_o, WriteData_o,
           WriteDataNum_o, wb_valid_o, err_o} !== '0) begin
         bad++;
         $display("FAIL rstmid_outs got busy=%b req=%b addr=%h data=%h",
                  busy_o, bus_req_o, bus_addr_o, WriteData_o);
      end
      clk1();
      rst_n = 1'b1;
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'h55555555;
      clk1();
      bus_ack_i = 1'b0;
      bus_rdata_i = '0;
      total++;
      if ({busy_o, bus_req_o, wb_valid_o, WriteData_o} !== '0) begin
         bad++;
         $display("FAIL stray_ack got busy=%b req=%b wb=%b data=%h",
                  busy_o, bus_req_o, wb_valid_o, WriteData_o);
      end
      do_store(SW, 32'h600, 32'h11223344, 0, 4'b1111, 32'h11223344, n);
   endtask

   initial begin
      test_reset();
      test_illegal_op();
      test_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      repeat (2) clk1();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
